// File: rtl/dly_chan.sv
// Multi-channel programmable pulse delay: per-channel down-counter with
// abort, retrigger policy, periodic auto-repeat and missed-trigger reporting.
module dly_chan #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned W      = 8,
  parameter bit          RETRIG = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    in,
  input  logic [NCH*W-1:0]  dly,
  input  logic [NCH-1:0]    rep,
  input  logic [NCH-1:0]    abort,
  output logic [NCH-1:0]    p,
  output logic [NCH-1:0]    busy,
  output logic [NCH-1:0]    miss
);

  localparam logic [W-1:0] ONE = W'(1);

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [W-1:0] cnt, cnt_nxt, dk, de;
    logic         miss_q, miss_nxt;
    logic         load_ok;

    assign dk = dly[k*W +: W];
    assign de = (dk == '0) ? ONE : dk;

    // A trigger in the final cycle of a non-repeating count is a fresh load,
    // so the RETRIG=0 policy only rejects it when the channel stays busy.
    assign load_ok = (cnt == '0) || RETRIG || ((cnt == ONE) && !rep[k]);

    always_comb begin
      cnt_nxt  = cnt;
      miss_nxt = 1'b0;
      if (abort[k]) begin
        cnt_nxt = '0;
      end else if (in[k] && load_ok) begin
        cnt_nxt = de;
      end else begin
        miss_nxt = in[k];
        if (cnt == ONE)
          cnt_nxt = rep[k] ? de : '0;
        else if (cnt != '0)
          cnt_nxt = cnt - ONE;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt    <= '0;
        miss_q <= 1'b0;
      end else begin
        cnt    <= cnt_nxt;
        miss_q <= miss_nxt;
      end
    end

    assign p[k]    = (cnt == ONE) && !abort[k];
    assign busy[k] = (cnt != '0);
    assign miss[k] = miss_q;
  end

endmodule

// File: tb/tb_dly_chan.sv
// Self-checking bench for dly_chan: two instances (RETRIG=1 and RETRIG=0) driven
// in parallel and compared against a deadline-based reference model.
module tb_dly_chan;
  localparam int NCH = 4;
  localparam int W   = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [NCH-1:0]  in, rep, abort;
  logic [NCH*W-1:0] dly;
  logic [NCH-1:0]  p1, busy1, miss1;
  logic [NCH-1:0]  p0, busy0, miss0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Model: absolute edge index at which the pending pulse is sampled (0 = idle).
  int cyc = 1;
  int dl [2][NCH];
  bit ms [2][NCH];

  always #5 clk = ~clk;

  dly_chan #(.NCH(NCH), .W(W), .RETRIG(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in(in), .dly(dly), .rep(rep), .abort(abort),
    .p(p1), .busy(busy1), .miss(miss1)
  );

  dly_chan #(.NCH(NCH), .W(W), .RETRIG(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in(in), .dly(dly), .rep(rep), .abort(abort),
    .p(p0), .busy(busy0), .miss(miss0)
  );

  task automatic check(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s at edge %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NCH; k++) begin
        dl[r][k] = 0;
        ms[r][k] = 1'b0;
      end
  endtask

  task automatic check_outputs();
    logic [NCH-1:0] ep [2];
    logic [NCH-1:0] eb [2];
    logic [NCH-1:0] em [2];
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NCH; k++) begin
        ep[r][k] = (dl[r][k] == cyc) && !abort[k];
        eb[r][k] = (dl[r][k] != 0);
        em[r][k] = ms[r][k];
      end
    check("p_retrig1",    p1,    ep[1]);
    check("busy_retrig1", busy1, eb[1]);
    check("miss_retrig1", miss1, em[1]);
    check("p_retrig0",    p0,    ep[0]);
    check("busy_retrig0", busy0, eb[0]);
    check("miss_retrig0", miss0, em[0]);
  endtask

  task automatic model_edge();
    int  de;
    bit  pc;
    bit  m;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NCH; k++) begin
        de = int'(dly[k*W +: W]);
        if (de == 0) de = 1;
        pc = (dl[r][k] == cyc);
        m  = 1'b0;
        if (abort[k])
          dl[r][k] = 0;
        else if (in[k] && (dl[r][k] == 0 || r == 1 || (pc && !rep[k])))
          dl[r][k] = cyc + de;
        else begin
          m = in[k];
          if (pc) dl[r][k] = rep[k] ? cyc + de : 0;
        end
        ms[r][k] = m;
      end
  endtask

  // One clock: check mid-cycle, advance model at the edge, then drop pulse inputs.
  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    in    = '0;
    abort = '0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_dly(input int k, input int v);
    dly[k*W +: W] = W'(v);
  endtask

  initial begin
    reset = 1'b0;
    in    = '0;
    rep   = '0;
    abort = '0;
    dly   = '0;
    model_clear();
    #1;
    check("reset_p",    p1 | p0,       '0);
    check("reset_busy", busy1 | busy0, '0);
    check("reset_miss", miss1 | miss0, '0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Basic delay of 5 on channel 0.
    set_dly(0, 5); in[0] = 1'b1; step();
    steps(8);

    // Zero delay treated as one, then the maximum delay.
    set_dly(1, 0); in[1] = 1'b1; step();
    steps(3);
    set_dly(1, 255); in[1] = 1'b1; step();
    set_dly(1, 3);
    steps(258);

    // Retrigger while busy: restart on one instance, miss on the other.
    set_dly(2, 10); in[2] = 1'b1; step();
    steps(3);
    in[2] = 1'b1; step();
    steps(14);

    // Auto-repeat with delay change in a p cycle, then repeat dropped.
    set_dly(3, 3); rep[3] = 1'b1; in[3] = 1'b1; step();
    steps(5);
    set_dly(3, 2); step();
    steps(2);
    rep[3] = 1'b0;
    steps(6);

    // Trigger in the p cycle without repeat, and with repeat.
    set_dly(2, 4); in[2] = 1'b1; step();
    steps(3);
    in[2] = 1'b1; step();
    steps(2);
    rep[2] = 1'b1; step();
    in[2] = 1'b1; step();
    rep[2] = 1'b0;
    steps(10);

    // Abort during the p cycle, then abort with trigger while idle.
    set_dly(0, 6); in[0] = 1'b1; step();
    steps(5);
    abort[0] = 1'b1; step();
    steps(3);
    abort[0] = 1'b1; in[0] = 1'b1; step();
    steps(3);

    // Asynchronous reset mid-count discards the pending pulse.
    set_dly(0, 8); in[0] = 1'b1; step();
    steps(2);
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    check("async_reset_p",    p1 | p0,       '0);
    check("async_reset_busy", busy1 | busy0, '0);
    check("async_reset_miss", miss1 | miss0, '0);
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b1;
    steps(10);
    in[0] = 1'b1; step();
    steps(10);

    // Randomised traffic on all channels.
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < NCH; k++) begin
        in[k]    = ($urandom_range(0, 7) == 0);
        abort[k] = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 15) == 0) rep[k] = ~rep[k];
        if ($urandom_range(0, 3) == 0) set_dly(k, int'($urandom_range(0, 12)));
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
